// File: rtl/mode_s_pkg.sv
// Shared types and default timing for the Mode S uplink preamble detector.
// Counts are in clock cycles at 16 clk/us.
package mode_s_pkg;

  localparam int CLK_PER_US   = 16;
  localparam int PW_MIN_DEF   = 11;
  localparam int PW_MAX_DEF   = 14;
  localparam int P2_OFS_DEF   = 32;
  localparam int P6_OFS_DEF   = 56;
  localparam int SYNC_OFS_DEF = 20;
  localparam int TOL_DEF      = 2;

  typedef logic [7:0] count_t;

  localparam count_t CNT_MAX = 8'hFF;

  typedef enum logic [2:0] {
    IDLE,
    P1_HI,
    GAP,
    P2_HI,
    P6_WAIT,
    SYNC,
    HOLD
  } state_t;

  function automatic count_t sat_inc(input count_t v);
    return (v == CNT_MAX) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/mode_s_edge_detect.sv
// Input conditioning for the preamble detector: optional two-flop synchronizer
// (MODE_S_VIDEO_SYNC_EN) followed by video rise/fall detection.
module mode_s_edge_detect (
  input  logic clk,
  input  logic reset,
  input  logic video,
  input  logic phase_rev,
  output logic video_s,
  output logic phase_rev_s,
  output logic rise,
  output logic fall
);

`ifdef MODE_S_VIDEO_SYNC_EN
  logic [1:0] vid_sync;
  logic [1:0] rev_sync;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vid_sync <= 2'b00;
      rev_sync <= 2'b00;
    end else begin
      vid_sync <= {vid_sync[0], video};
      rev_sync <= {rev_sync[0], phase_rev};
    end
  end

  assign video_s     = vid_sync[1];
  assign phase_rev_s = rev_sync[1];
`else
  assign video_s     = video;
  assign phase_rev_s = phase_rev;
`endif

  logic video_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) video_q <= 1'b0;
    else       video_q <= video_s;
  end

  assign rise = video_s & ~video_q;
  assign fall = ~video_s & video_q;

endmodule

// File: rtl/mode_s_preamble_detector.sv
// Mode S uplink preamble qualifier: P1/P2 pair, P6 leading edge, DPSK sync
// reversal. Build with MODE_S_VIDEO_SYNC_EN to synchronize video/phase_rev.
module mode_s_preamble_detector
  import mode_s_pkg::*;
#(
  parameter int PW_MIN   = PW_MIN_DEF,
  parameter int PW_MAX   = PW_MAX_DEF,
  parameter int P2_OFS   = P2_OFS_DEF,
  parameter int P6_OFS   = P6_OFS_DEF,
  parameter int SYNC_OFS = SYNC_OFS_DEF,
  parameter int TOL      = TOL_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic video,
  input  logic phase_rev,
  output logic pulse_received,
  output logic p6_sync_phase_rev,
  output logic preamble_fail,
  output logic busy
);

  localparam count_t PW_LO      = count_t'(PW_MIN);
  localparam count_t PW_HI      = count_t'(PW_MAX);
  localparam count_t P2_WIN_LO  = count_t'(P2_OFS - TOL);
  localparam count_t P2_WIN_HI  = count_t'(P2_OFS + TOL);
  localparam count_t P6_WIN_LO  = count_t'(P6_OFS - TOL);
  localparam count_t P6_WIN_HI  = count_t'(P6_OFS + TOL);
  localparam count_t SY_WIN_LO  = count_t'(SYNC_OFS - TOL);
  localparam count_t SY_WIN_HI  = count_t'(SYNC_OFS + TOL);

  logic video_s, phase_rev_s, rise, fall;

  mode_s_edge_detect u_edge (
    .clk         (clk),
    .reset       (reset),
    .video       (video),
    .phase_rev   (phase_rev),
    .video_s     (video_s),
    .phase_rev_s (phase_rev_s),
    .rise        (rise),
    .fall        (fall)
  );

  state_t state, state_n;
  count_t cnt, cnt_n, wcnt, wcnt_n, scnt, scnt_n;
  logic   pr_n, sync_n, fail_n;
  logic   width_ok;

  // Counters are loaded with 1 on an edge so that the value seen in cycle k
  // after the edge is k: the edge cycle itself counts as 0.
  assign width_ok = (wcnt >= PW_LO) && (wcnt <= PW_HI);

  always_comb begin
    state_n = state;
    cnt_n   = sat_inc(cnt);
    wcnt_n  = video_s ? sat_inc(wcnt) : wcnt;
    scnt_n  = sat_inc(scnt);
    pr_n    = 1'b0;
    sync_n  = 1'b0;
    fail_n  = 1'b0;
    case (state)
      IDLE: begin
        if (rise) begin
          state_n = P1_HI;
          cnt_n   = 8'd1;
          wcnt_n  = 8'd1;
        end
      end
      P1_HI: begin
        if (fall) state_n = width_ok ? GAP : IDLE;
      end
      GAP: begin
        if (rise) begin
          if (cnt >= P2_WIN_LO && cnt <= P2_WIN_HI) begin
            state_n = P2_HI;
            wcnt_n  = 8'd1;
          end else if (cnt < P2_WIN_LO) begin
            state_n = P1_HI;
            cnt_n   = 8'd1;
            wcnt_n  = 8'd1;
          end else begin
            state_n = IDLE;
          end
        end else if (cnt > P2_WIN_HI) begin
          state_n = IDLE;
        end
      end
      P2_HI: begin
        if (fall) begin
          if (width_ok) begin
            state_n = P6_WAIT;
            pr_n    = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      P6_WAIT: begin
        if (rise && cnt >= P6_WIN_LO && cnt <= P6_WIN_HI) begin
          state_n = SYNC;
          scnt_n  = 8'd1;
        end else if (rise || cnt > P6_WIN_HI) begin
          state_n = IDLE;
          fail_n  = 1'b1;
        end
      end
      SYNC: begin
        // A reversal coinciding with the end of P6 still counts; HOLD is
        // skipped because the fall it would wait for has already happened.
        if (phase_rev_s && scnt >= SY_WIN_LO && scnt <= SY_WIN_HI) begin
          state_n = fall ? IDLE : HOLD;
          sync_n  = 1'b1;
        end else if (phase_rev_s || scnt > SY_WIN_HI || fall) begin
          state_n = IDLE;
          fail_n  = 1'b1;
        end
      end
      HOLD: begin
        if (fall) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Outputs are one-cycle strobes with no ready side: the consumer must take
  // each one in the cycle it is high.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= IDLE;
      cnt               <= '0;
      wcnt              <= '0;
      scnt              <= '0;
      pulse_received    <= 1'b0;
      p6_sync_phase_rev <= 1'b0;
      preamble_fail     <= 1'b0;
      busy              <= 1'b0;
    end else begin
      state             <= state_n;
      cnt               <= cnt_n;
      wcnt              <= wcnt_n;
      scnt              <= scnt_n;
      pulse_received    <= pr_n;
      p6_sync_phase_rev <= sync_n;
      preamble_fail     <= fail_n;
      busy              <= (state_n != IDLE);
    end
  end

endmodule
